acq_packet_framer: RTL and testbench

- Downstream stage of the acquisition switcher: consumes the muxed 16-bit test data stream and its enable, buffers it, and frames it into fixed-format packets for the external USB FIFO.
- Returns a backpressure flag to the switcher, which distributes it as its external-FIFO-full input.
- Gives host software packet boundaries, a mode tag, a sequence number and a word count for every acquisition mode (Microroc, SCurve, ADC).

---
 rtl/acq_packet_framer_pkg.sv | 32 +++
 rtl/acq_packet_framer_fifo.sv | 53 +++++
 rtl/acq_packet_framer.sv | 154 +++++++++++++++
 tb/tb_acq_packet_framer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_packet_framer_pkg.sv
// Shared constants for the acquisition packet framer: framing words, FSM
// encoding and tag-word field layout.
package acq_packet_framer_pkg;

  localparam logic [15:0] HEADER_WORD_DEF  = 16'hA55A;
  localparam logic [15:0] TRAILER_WORD_DEF = 16'h5AA5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_TAG  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_CNT  = 3'd4;
  localparam logic [2:0] ST_TAIL = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    HEAD = ST_HEAD,
    TAG  = ST_TAG,
    PAY  = ST_PAY,
    CNT  = ST_CNT,
    TAIL = ST_TAIL
  } frm_state_e;

  localparam int TAG_MODE_LSB = 12;
  localparam int TAG_SEQ_W    = 12;

  function automatic logic [15:0] make_tag(input logic [3:0] mode,
                                           input logic [TAG_SEQ_W-1:0] seq);
    return {mode, seq};
  endfunction

endpackage

// File: rtl/acq_packet_framer_fifo.sv
// Input buffer: synchronous FIFO with registered count. The head word is
// presented combinationally from the registered read pointer.
module packet_sync_fifo #(
  parameter int ADDR_W = 6,
  parameter int W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            wr_en_i,
  input  logic [W-1:0]    wr_data_i,
  input  logic            rd_en_i,
  output logic [W-1:0]    rd_data_o,
  output logic [ADDR_W:0] count_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int DEPTH = 2**ADDR_W;

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q;
  logic              wr, rd;

  assign full_o    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rptr_q];
  assign wr        = wr_en_i & ~full_o & ~clr_i;
  assign rd        = rd_en_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
      if (wr && !rd)      count_q <= count_q + 1'b1;
      else if (rd && !wr) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/acq_packet_framer.sv
// Frames the switcher's 16-bit test data stream into header/tag/payload/
// count/trailer packets for the external USB FIFO, with backpressure.
module acq_packet_framer
  import acq_packet_framer_pkg::*;
#(
  parameter int          ADDR_W       = 6,
  parameter int          PAYLOAD_MAX  = 256,
  parameter int          AFULL_MARGIN = 4,
  parameter logic [15:0] HEADER_WORD  = HEADER_WORD_DEF,
  parameter logic [15:0] TRAILER_WORD = TRAILER_WORD_DEF
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [3:0]  ModeSelect,
  input  logic        StartStop,
  input  logic        Flush,
  input  logic [15:0] InData,
  input  logic        InDataEnable,
  input  logic        ExtFifoFull,
  output logic [15:0] OutData,
  output logic        OutDataEnable,
  output logic        InBufferFull,
  output logic        Overflow,
  output logic [15:0] PacketCount
);
  localparam int DEPTH = 2**ADDR_W;

  frm_state_e  state_q, state_d;
  logic        ss_q, clr_req_q, clr_req_d, fpend_q, fpend_d;
  logic        ovf_q, ovf_d, ibf_q, ibf_d, vld_q, vld_d;
  logic [3:0]  mode_q, mode_d;
  logic [11:0] seq_q, seq_d, n_q, n_d, pay_q, pay_d, n_load;
  logic [15:0] pkt_q, pkt_d, out_q, out_d;

  logic            rise, fall, idle, clr, issue, rd_en, pkt_done, trig_full;
  logic [15:0]     rd_data;
  logic [ADDR_W:0] cnt;
  logic            full, empty;

  packet_sync_fifo #(.ADDR_W(ADDR_W), .W(16)) u_fifo (
    .clk(Clk), .rst_n(reset_n), .clr_i(clr),
    .wr_en_i(InDataEnable), .wr_data_i(InData),
    .rd_en_i(rd_en), .rd_data_o(rd_data),
    .count_o(cnt), .full_o(full), .empty_o(empty)
  );

  assign rise      = StartStop & ~ss_q;
  assign fall      = ~StartStop & ss_q;
  assign idle      = (state_q == IDLE);
  // A restart request waits for IDLE so an in-flight packet is never torn.
  assign clr       = (rise | clr_req_q) & idle;
  assign issue     = ~idle & ~ExtFifoFull;
  assign trig_full = (int'(cnt) >= PAYLOAD_MAX);
  assign n_load    = trig_full ? 12'(PAYLOAD_MAX) : 12'(cnt);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    pay_d    = pay_q;
    seq_d    = seq_q;
    pkt_d    = pkt_q;
    out_d    = out_q;
    vld_d    = issue;
    rd_en    = 1'b0;
    pkt_done = 1'b0;
    unique case (state_q)
      IDLE: if (!clr && (trig_full || (fpend_q && !empty))) begin
        state_d = HEAD;
        n_d     = n_load;
        pay_d   = '0;
      end
      HEAD: if (issue) begin
        out_d   = HEADER_WORD;
        state_d = TAG;
      end
      TAG: if (issue) begin
        out_d   = make_tag(mode_q, seq_q);
        state_d = PAY;
      end
      PAY: if (issue) begin
        out_d = rd_data;
        rd_en = 1'b1;
        pay_d = pay_q + 12'd1;
        if (pay_q == n_q - 12'd1) state_d = CNT;
      end
      CNT: if (issue) begin
        out_d   = {4'h0, n_q};
        state_d = TAIL;
      end
      TAIL: if (issue) begin
        out_d    = TRAILER_WORD;
        seq_d    = seq_q + 12'd1;
        pkt_d    = (pkt_q == 16'hFFFF) ? pkt_q : pkt_q + 16'd1;
        pkt_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    clr_req_d = (rise | clr_req_q) & ~idle;
    mode_d    = clr ? ModeSelect : mode_q;
    ovf_d     = ovf_q | (InDataEnable & full);
    ibf_d     = (DEPTH - int'(cnt)) <= AFULL_MARGIN;

    fpend_d = fpend_q;
    if ((pkt_done || idle) && empty) fpend_d = 1'b0;
    if (clr) begin
      seq_d   = '0;
      pkt_d   = '0;
      ovf_d   = 1'b0;
      fpend_d = 1'b0;
    end
    if (Flush || fall) fpend_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ss_q      <= 1'b0;
      clr_req_q <= 1'b0;
      fpend_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ibf_q     <= 1'b0;
      vld_q     <= 1'b0;
      mode_q    <= '0;
      seq_q     <= '0;
      n_q       <= '0;
      pay_q     <= '0;
      pkt_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      ss_q      <= StartStop;
      clr_req_q <= clr_req_d;
      fpend_q   <= fpend_d;
      ovf_q     <= ovf_d;
      ibf_q     <= ibf_d;
      vld_q     <= vld_d;
      mode_q    <= mode_d;
      seq_q     <= seq_d;
      n_q       <= n_d;
      pay_q     <= pay_d;
      pkt_q     <= pkt_d;
      out_q     <= out_d;
    end
  end

  assign OutData       = out_q;
  assign OutDataEnable = vld_q;
  assign InBufferFull  = ibf_q;
  assign Overflow      = ovf_q;
  assign PacketCount   = pkt_q;

endmodule

// File: tb/tb_acq_packet_framer.sv
// Directed bench for acq_packet_framer: a queue-based packet model predicts
// every issued word; literal word lists pin the model for the key scenarios.
module tb_acq_packet_framer;
  localparam int PMAX  = 4;
  localparam int DEPTH = 64;

  logic        Clk = 1'b0, reset_n = 1'b0;
  logic [3:0]  ModeSelect = '0;
  logic        StartStop = 1'b0, Flush = 1'b0, InDataEnable = 1'b0, ExtFifoFull = 1'b0;
  logic [15:0] InData = '0;
  logic [15:0] OutData, PacketCount;
  logic        OutDataEnable, InBufferFull, Overflow;

  acq_packet_framer #(
    .ADDR_W(6), .PAYLOAD_MAX(PMAX), .AFULL_MARGIN(4),
    .HEADER_WORD(16'hA55A), .TRAILER_WORD(16'h5AA5)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .ModeSelect(ModeSelect), .StartStop(StartStop),
    .Flush(Flush), .InData(InData), .InDataEnable(InDataEnable),
    .ExtFifoFull(ExtFifoFull), .OutData(OutData), .OutDataEnable(OutDataEnable),
    .InBufferFull(InBufferFull), .Overflow(Overflow), .PacketCount(PacketCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] data;
    logic        head;
    logic        tail;
    logic [11:0] n;
  } exp_t;

  exp_t        expq[$];
  exp_t        explog[$];
  logic [15:0] mbuf[$];
  logic [3:0]  m_mode = '0;
  logic [11:0] m_seq = '0;
  int          m_pkts = 0;
  logic [15:0] last_tag = '0;
  int          n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [15:0] d, input logic h, input logic t,
                               input logic [11:0] n);
    exp_t e;
    e.data = d; e.head = h; e.tail = t; e.n = n;
    expq.push_back(e);
    explog.push_back(e);
  endfunction

  function automatic void m_emit(input int n);
    push(16'hA55A, 1'b1, 1'b0, '0);
    push({m_mode, m_seq}, 1'b0, 1'b0, '0);
    if (m_pkts == 4096) last_tag = {m_mode, m_seq};
    for (int i = 0; i < n; i++) push(mbuf.pop_front(), 1'b0, 1'b0, '0);
    push({4'h0, 12'(n)}, 1'b0, 1'b0, '0);
    push(16'h5AA5, 1'b0, 1'b1, 12'(n));
    m_seq = m_seq + 12'd1;
    if (m_pkts < 65535) m_pkts++;
  endfunction

  function automatic void m_write(input logic [15:0] w);
    mbuf.push_back(w);
    if (mbuf.size() >= PMAX) m_emit(PMAX);
  endfunction

  function automatic void m_flush();
    while (mbuf.size() > 0) m_emit(mbuf.size() < PMAX ? mbuf.size() : PMAX);
  endfunction

  function automatic void m_clear(input logic [3:0] m);
    mbuf.delete();
    m_mode = m;
    m_seq  = '0;
    m_pkts = 0;
  endfunction

  // Per-cycle output checker.
  logic efull_e;
  int   run_len = 0;
  bit   stall_seen = 0;
  exp_t cur;
  always @(posedge Clk) begin
    efull_e = ExtFifoFull;
    #1;
    if (!reset_n) begin
      run_len = 0;
    end else begin
      if (efull_e) begin
        stall_seen = 1;
        check("no_issue_when_full", {31'd0, OutDataEnable}, 32'd0);
      end
      if (OutDataEnable) begin
        run_len++;
        if (expq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", OutData);
        end else begin
          cur = expq.pop_front();
          if (cur.head) stall_seen = 0;
          check("out_word", {16'd0, OutData}, {16'd0, cur.data});
          if (cur.tail && !stall_seen)
            check("pkt_cycles", run_len, 32'(cur.n) + 32'd4);
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wr(input logic [15:0] w, input bit model = 1);
    InData = w; InDataEnable = 1'b1;
    tick();
    InDataEnable = 1'b0;
    if (model) m_write(w);
  endtask

  task automatic do_flush();
    Flush = 1'b1; tick(); Flush = 1'b0;
    m_flush();
  endtask

  task automatic drain(input string name, input int limit);
    int c = 0;
    while (expq.size() != 0 && c < limit) begin tick(); c++; end
    check(name, expq.size(), 0);
    expq.delete();
    tick(4);
    check({name, "_pktcount"}, {16'd0, PacketCount}, 32'(m_pkts));
  endtask

  task automatic start_clear(input logic [3:0] m);
    StartStop = 1'b0; tick(3);
    ModeSelect = m; StartStop = 1'b1; tick(4);
    m_clear(m);
  endtask

  task automatic pin(input string name, input logic [15:0] lit[$]);
    check({name, "_len"}, explog.size(), lit.size());
    for (int i = 0; i < lit.size() && i < explog.size(); i++)
      check($sformatf("%s[%0d]", name, i), {16'd0, explog[i].data}, {16'd0, lit[i]});
  endtask

  initial begin
    logic [15:0] lit[$];
    int sent, guard, c;

    tick(3);
    check("rst_outdata", {16'd0, OutData}, 0);
    check("rst_oe", {31'd0, OutDataEnable}, 0);
    check("rst_ibf", {31'd0, InBufferFull}, 0);
    check("rst_ovf", {31'd0, Overflow}, 0);
    check("rst_pktcnt", {16'd0, PacketCount}, 0);
    reset_n = 1'b1; tick(2);

    // Two full packets from 8 back-to-back words.
    start_clear(4'h2);
    explog.delete();
    for (int i = 1; i <= 8; i++) wr(16'(i));
    drain("t1_drain", 200);
    lit = '{16'hA55A, 16'h2000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004, 16'h5AA5,
            16'hA55A, 16'h2001, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0004, 16'h5AA5};
    pin("t1", lit);
    check("t1_pktcount_lit", {16'd0, PacketCount}, 2);

    // Short packet closed by Flush, then Flush on an empty buffer.
    explog.delete();
    wr(16'h0011); wr(16'h0012); wr(16'h0013);
    tick(5);
    do_flush();
    drain("t2_drain", 200);
    lit = '{16'hA55A, 16'h2002, 16'h0011, 16'h0012, 16'h0013, 16'h0003, 16'h5AA5};
    pin("t2", lit);
    do_flush();
    tick(10);
    check("t2_empty_flush_pktcount", {16'd0, PacketCount}, 3);

    // Stalls toggled every 3 cycles mid-packet.
    explog.delete();
    ExtFifoFull = 1'b1;
    for (int i = 0; i < 4; i++) wr(16'h0021 + 16'(i));
    for (int i = 0; i < 16; i++) begin ExtFifoFull = (i % 2 == 0); tick(3); end
    ExtFifoFull = 1'b0;
    drain("t3_drain", 200);
    lit = '{16'hA55A, 16'h2003, 16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0004, 16'h5AA5};
    pin("t3", lit);

    // Buffer fill with the output blocked: almost-full and overflow.
    start_clear(4'h5);
    check("t4_clr_pktcount", {16'd0, PacketCount}, 0);
    ExtFifoFull = 1'b1;
    for (int i = 0; i < 59; i++) wr(16'h0100 + 16'(i));
    tick(2);
    check("t4_ibf_59", {31'd0, InBufferFull}, 0);
    wr(16'h0100 + 16'd59);
    tick(2);
    check("t4_ibf_60", {31'd0, InBufferFull}, 1);
    for (int i = 60; i < 64; i++) wr(16'h0100 + 16'(i));
    tick(2);
    check("t4_ovf_before_drop", {31'd0, Overflow}, 0);
    wr(16'h0140, 0); wr(16'h0141, 0);
    tick(2);
    check("t4_ovf", {31'd0, Overflow}, 1);
    check("t4_ibf_full", {31'd0, InBufferFull}, 1);
    ExtFifoFull = 1'b0;
    drain("t4_drain", 2000);
    check("t4_pktcount_lit", {16'd0, PacketCount}, 16);
    start_clear(4'h5);
    check("t4_ovf_cleared", {31'd0, Overflow}, 0);
    check("t4_pktcount_cleared", {16'd0, PacketCount}, 0);

    // Reset in the middle of a payload.
    for (int i = 0; i < 4; i++) wr(16'h0031 + 16'(i));
    c = 0;
    while (expq.size() > 5 && c < 100) begin tick(); c++; end
    check("t5_reached_pay", expq.size(), 5);
    reset_n = 1'b0; #1;
    check("t5_rst_outdata", {16'd0, OutData}, 0);
    check("t5_rst_oe", {31'd0, OutDataEnable}, 0);
    check("t5_rst_pktcnt", {16'd0, PacketCount}, 0);
    check("t5_rst_ibf", {31'd0, InBufferFull}, 0);
    expq.delete();
    tick(2);
    ModeSelect = 4'h9;
    reset_n = 1'b1;
    tick(4);
    m_clear(4'h9);
    explog.delete();
    wr(16'h0041); wr(16'h0042); wr(16'h0043);
    do_flush();
    drain("t5_drain", 200);
    lit = '{16'hA55A, 16'h9000, 16'h0041, 16'h0042, 16'h0043, 16'h0003, 16'h5AA5};
    pin("t5", lit);

    // 4097 packets: sequence wrap.
    start_clear(4'hC);
    sent = 0; guard = 0;
    while (sent < 4097 * PMAX && guard < 80000) begin
      if (!InBufferFull) begin wr(16'(sent)); sent++; end
      else tick();
      guard++;
    end
    check("t6_all_sent", sent, 4097 * PMAX);
    drain("t6_drain", 2000);
    check("t6_pktcount_lit", {16'd0, PacketCount}, 4097);
    check("t6_wrap_tag", {16'd0, last_tag}, 32'h0000C000);
    check("t6_ovf", {31'd0, Overflow}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
